// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: builds operand A, an operator and operand B from key presses, issues a valid/ready request to the ALU and holds the result for display.
// Optional build macro KEYPAD_ENTRY_CHAIN_EN: an operator key in DONE chains the previous result into operand A.
module keypad_entry_ctrl #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       digit,
  input  logic             push,
  input  logic             calc_ready,
  input  logic [WIDTH-1:0] result,
  input  logic             result_valid,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       op,
  output logic             calc_valid,
  output logic [WIDTH-1:0] disp_value,
  output logic [2:0]       entry_state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_DIGITS);
  localparam logic [WIDTH-1:0] TEN     = WIDTH'(10);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             push_d_q;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic [CW-1:0]    cnta_q, cnta_d, cntb_q, cntb_d;
  logic [1:0]       op_q, op_d;
  logic             calc_valid_q, calc_valid_d;

  logic key_ev, is_digit, is_op, is_eq, is_clr, clr_all, load_digit;

  function automatic logic [WIDTH-1:0] append_digit(input logic [WIDTH-1:0] acc,
                                                    input logic [3:0]       d);
    return acc * TEN + WIDTH'(d);
  endfunction

  always_comb begin
    key_ev   = push & ~push_d_q;
    is_digit = (digit < 4'd10);
    is_op    = (digit >= 4'd10) && (digit <= 4'd13);
    is_eq    = (digit == 4'd14);
    is_clr   = (digit == 4'd15);

    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    cnta_d       = cnta_q;
    cntb_d       = cntb_q;
    op_d         = op_q;
    res_d        = res_q;
    calc_valid_d = calc_valid_q;
    clr_all      = 1'b0;
    load_digit   = 1'b0;

    case (state_q)
      ENTER_A: begin
        if (key_ev) begin
          if (is_clr) begin
            clr_all = 1'b1;
          end else if (is_digit) begin
            if (cnta_q != CNT_MAX) begin
              a_d    = append_digit(a_q, digit);
              cnta_d = cnta_q + 1'b1;
            end
          end else if (is_op && (cnta_q != '0)) begin
            op_d    = 2'(digit - 4'd10);
            b_d     = '0;
            cntb_d  = '0;
            state_d = ENTER_B;
          end
        end
      end
      ENTER_B: begin
        if (key_ev) begin
          if (is_clr) begin
            clr_all = 1'b1;
          end else if (is_digit) begin
            if (cntb_q != CNT_MAX) begin
              b_d    = append_digit(b_q, digit);
              cntb_d = cntb_q + 1'b1;
            end
          end else if (is_op) begin
            if (cntb_q == '0) op_d = 2'(digit - 4'd10);
          end else if (is_eq && (cntb_q != '0)) begin
            calc_valid_d = 1'b1;
            state_d      = ISSUE;
          end
        end
      end
      // Operands and operator are frozen here; every key, clear included, is dropped.
      ISSUE: begin
        if (calc_ready) begin
          calc_valid_d = 1'b0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (result_valid) begin
          res_d   = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (key_ev) begin
          if (is_clr) begin
            clr_all = 1'b1;
          end else if (is_digit) begin
            clr_all    = 1'b1;
            load_digit = 1'b1;
          end else if (is_op) begin
`ifdef KEYPAD_ENTRY_CHAIN_EN
            a_d     = res_q;
            cnta_d  = CNT_MAX;
            op_d    = 2'(digit - 4'd10);
            b_d     = '0;
            cntb_d  = '0;
            state_d = ENTER_B;
`endif
          end
        end
      end
      default: begin
        state_d      = ENTER_A;
        calc_valid_d = 1'b0;
      end
    endcase

    if (clr_all) begin
      a_d     = '0;
      b_d     = '0;
      cnta_d  = '0;
      cntb_d  = '0;
      op_d    = '0;
      res_d   = '0;
      state_d = ENTER_A;
    end
    if (load_digit) begin
      a_d    = WIDTH'(digit);
      cnta_d = CW'(1);
    end

    // Display is registered, so derive it from the next-state values.
    case (state_d)
      ENTER_B: disp_d = (cntb_d != '0) ? b_d : a_d;
      DONE:    disp_d = res_d;
      default: disp_d = a_d;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ENTER_A;
      push_d_q     <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      cnta_q       <= '0;
      cntb_q       <= '0;
      op_q         <= '0;
      res_q        <= '0;
      disp_q       <= '0;
      calc_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      push_d_q     <= push;
      a_q          <= a_d;
      b_q          <= b_d;
      cnta_q       <= cnta_d;
      cntb_q       <= cntb_d;
      op_q         <= op_d;
      res_q        <= res_d;
      disp_q       <= disp_d;
      calc_valid_q <= calc_valid_d;
    end
  end

  assign operand_a   = a_q;
  assign operand_b   = b_q;
  assign op          = op_q;
  assign calc_valid  = calc_valid_q;
  assign disp_value  = disp_q;
  assign entry_state = state_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl; follows KEYPAD_ENTRY_CHAIN_EN for the DONE operator-key case.
module tb_keypad_entry_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  digit;
  logic        push;
  logic        calc_ready;
  logic [15:0] result;
  logic        result_valid;
  logic [15:0] operand_a, operand_b, disp_value;
  logic [1:0]  op;
  logic        calc_valid;
  logic [2:0]  entry_state;

  int checks   = 0;
  int failures = 0;

  keypad_entry_ctrl #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .digit        (digit),
    .push         (push),
    .calc_ready   (calc_ready),
    .result       (result),
    .result_valid (result_valid),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .op           (op),
    .calc_valid   (calc_valid),
    .disp_value   (disp_value),
    .entry_state  (entry_state)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One key press: push high across one rising edge, released on the next falling edge.
  task automatic press(input logic [3:0] k);
    @(negedge clock);
    digit = k;
    push  = 1'b1;
    @(negedge clock);
    push  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; digit = 4'd0; push = 1'b0;
    calc_ready = 1'b1; result = 16'd0; result_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_val("rst_a",     operand_a,   0);
    check_val("rst_b",     operand_b,   0);
    check_val("rst_op",    op,          0);
    check_val("rst_cv",    calc_valid,  0);
    check_val("rst_disp",  disp_value,  0);
    check_val("rst_state", entry_state, 0);

    // 12 + 3 with ALU ready
    press(4'd1); press(4'd2);
    check_val("t1_disp12", disp_value, 12);
    press(4'd10);
    check_val("t1_stateB", entry_state, 1);
    press(4'd3);
    check_val("t1_disp3", disp_value, 3);
    press(4'd14);
    check_val("t1_cv_hi", calc_valid,  1);
    check_val("t1_issue", entry_state, 2);
    check_val("t1_a",     operand_a,   12);
    check_val("t1_b",     operand_b,   3);
    check_val("t1_op",    op,          0);
    @(negedge clock);
    check_val("t1_cv_lo", calc_valid,  0);
    check_val("t1_wait",  entry_state, 3);
    result = 16'd15; result_valid = 1'b1;
    @(negedge clock);
    result_valid = 1'b0;
    check_val("t1_done", entry_state, 4);
    check_val("t1_res",  disp_value,  15);

    // Operator key in DONE
    press(4'd12);
`ifdef KEYPAD_ENTRY_CHAIN_EN
    check_val("t5_chain_state", entry_state, 1);
    check_val("t5_chain_a",     operand_a,   15);
    check_val("t5_chain_disp",  disp_value,  15);
    press(4'd2);
    check_val("t5_chain_disp2", disp_value, 2);
    press(4'd14);
    check_val("t5_chain_a2", operand_a, 15);
    check_val("t5_chain_b",  operand_b, 2);
    check_val("t5_chain_op", op,        2);
    check_val("t5_chain_cv", calc_valid, 1);
    @(negedge clock);
    result = 16'd30; result_valid = 1'b1;
    @(negedge clock);
    result_valid = 1'b0;
    check_val("t5_chain_res", disp_value, 30);
`else
    check_val("t5_nochain_state", entry_state, 4);
    check_val("t5_nochain_disp",  disp_value,  15);
    press(4'd2);
    check_val("t5_nochain_stA",  entry_state, 0);
    check_val("t5_nochain_a",    operand_a,   2);
    check_val("t5_nochain_disp2", disp_value, 2);
    check_val("t5_nochain_op",   op,          0);
`endif
    press(4'd15);
    check_val("clr_state", entry_state, 0);
    check_val("clr_disp",  disp_value,  0);

    // Digit limit
    repeat (4) press(4'd9);
    check_val("t2_disp4", disp_value, 9999);
    press(4'd9);
    check_val("t2_a5",    operand_a,  9999);
    check_val("t2_disp5", disp_value, 9999);
    press(4'd15);

    // Held key gives one event
    @(negedge clock);
    digit = 4'd7; push = 1'b1;
    repeat (20) @(negedge clock);
    push = 1'b0;
    check_val("t3_hold_a", operand_a, 7);
    press(4'd14);
    check_val("t3_eq_in_A", entry_state, 0);
    check_val("t3_eq_disp", disp_value,  7);
    press(4'd15);
    press(4'd10);
    check_val("t3_op_cnt0", entry_state, 0);

    // Stalled ISSUE, clear ignored
    press(4'd4); press(4'd11); press(4'd5);
    calc_ready = 1'b0;
    press(4'd14);
    check_val("t4_issue", entry_state, 2);
    repeat (5) @(negedge clock);
    check_val("t4_cv_hold", calc_valid, 1);
    press(4'd15);
    check_val("t4_clr_cv",    calc_valid,  1);
    check_val("t4_clr_state", entry_state, 2);
    check_val("t4_a",         operand_a,   4);
    check_val("t4_b",         operand_b,   5);
    check_val("t4_op",        op,          1);
    calc_ready = 1'b1;
    @(negedge clock);
    calc_ready = 1'b0;
    check_val("t4_wait", entry_state, 3);
    check_val("t4_cv0",  calc_valid,  0);
    result = 16'hFFFF; result_valid = 1'b1;
    @(negedge clock);
    result_valid = 1'b0;
    check_val("t4_done", entry_state, 4);
    check_val("t4_disp", disp_value,  65535);
    press(4'd15);

    // Reset during ISSUE
    press(4'd6); press(4'd10); press(4'd7); press(4'd14);
    check_val("t6_issue", calc_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    check_val("t6_rst_cv",    calc_valid,  0);
    check_val("t6_rst_state", entry_state, 0);
    check_val("t6_rst_a",     operand_a,   0);
    reset = 1'b0;

    // Key held through reset is not counted
    digit = 4'd5; push = 1'b1; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_val("t7_held_a",    operand_a,  0);
    check_val("t7_held_disp", disp_value, 0);
    push = 1'b0;
    press(4'd5);
    check_val("t7_after_a", operand_a, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
